// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 transmitter.
// Inhibits the bus, issues request-to-send, shifts out one byte LSB-first with
// odd parity and a stop bit on device-generated clocks, then checks the ACK.
// Drive outputs are open-drain enables (1 = pull line low) and are ORed with
// the port receiver's enables outside this block.
module ps2_tx #(
  parameter int unsigned INHIBIT_US        = 120,
  parameter int unsigned START_TIMEOUT_US  = 15000,
  parameter int unsigned PACKET_TIMEOUT_US = 2000
) (
  input  logic       clk6x,
  input  logic       reset,
  input  logic       ck1us,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       PS2_CLKDR0,
  output logic       PS2_DATADR0,
  input  logic [7:0] code_tx_i,
  input  logic       code_tx_v_i,
  output logic       code_tx_ready_o,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_err_o,
  output logic [1:0] tx_errcode_o
);

  localparam logic [15:0] INHIBIT_LD = 16'(INHIBIT_US);
  localparam logic [15:0] START_LD   = 16'(START_TIMEOUT_US);
  localparam logic [15:0] PACKET_LD  = 16'(PACKET_TIMEOUT_US);

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_NO_CLK = 2'b01;
  localparam logic [1:0] ERR_PKT_TO = 2'b10;
  localparam logic [1:0] ERR_NO_ACK = 2'b11;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE = 3'd0,
    ST_IDLE      = 3'd1,
    ST_INHIBIT   = 3'd2,
    ST_RTS       = 3'd3,
    ST_WF_FIRST  = 3'd4,
    ST_BITS      = 3'd5,
    ST_ERR       = 3'd6,
    ST_DONE_WAIT = 3'd7
  } state_t;

  // Odd parity bit: makes the total count of ones (data + parity) odd.
  function automatic logic odd_parity(input logic [7:0] code);
    odd_parity = ~^code;
  endfunction

  // DATA drive enable to apply after device falling edge number fall_n.
  // Falls 1..8 present data bits LSB-first, fall 9 the parity bit, and from
  // fall 10 on the line is released (stop bit reads as 1).
  function automatic logic drive_bit(input logic [3:0] fall_n,
                                     input logic [7:0] code,
                                     input logic       par);
    logic [3:0] idx;
    idx = fall_n - 4'd1;
    case (fall_n)
      4'd1, 4'd2, 4'd3, 4'd4,
      4'd5, 4'd6, 4'd7, 4'd8: drive_bit = ~code[idx[2:0]];
      4'd9:                   drive_bit = ~par;
      default:                drive_bit = 1'b0;
    endcase
  endfunction

  // Line synchronisers (CLK gets one extra stage for edge detection).
  logic clk_d1_r, clk_d2_r, clk_d3_r;
  logic data_d1_r, data_d2_r;
  logic fall_s;

  // Microsecond timer.
  logic [15:0] timer_r;
  logic        timer_load_s;
  logic [15:0] timer_load_val_s;
  logic        expired_s;

  // Control state.
  state_t      state_r, state_nx_s;
  logic        accept_s;
  logic [7:0]  byte_r;
  logic        parity_r;
  logic [3:0]  bitcnt_r, bitcnt_nx_s;
  logic [3:0]  fall_n_s;
  logic [1:0]  reason_r, reason_nx_s;
  logic        datadr0_nx_s;
  logic        done_nx_s;
  logic        err_nx_s;

  // Registered outputs.
  logic        clkdr0_r;
  logic        datadr0_r;
  logic        ready_r;
  logic        busy_r;
  logic        done_r;
  logic        err_r;
  logic [1:0]  errcode_r;

  assign fall_s    = !clk_d2_r && clk_d3_r;
  assign expired_s = (timer_r == 16'd0);
  assign accept_s  = code_tx_v_i && ready_r;
  assign fall_n_s  = bitcnt_r + 4'd1;

  assign PS2_CLKDR0      = clkdr0_r;
  assign PS2_DATADR0     = datadr0_r;
  assign code_tx_ready_o = ready_r;
  assign tx_busy_o       = busy_r;
  assign tx_done_o       = done_r;
  assign tx_err_o        = err_r;
  assign tx_errcode_o    = errcode_r;

  // Bring the asynchronous bus lines into the clk6x domain; idle bus reads 1.
  always_ff @(posedge clk6x) begin
    if (reset) begin
      clk_d1_r  <= 1'b1;
      clk_d2_r  <= 1'b1;
      clk_d3_r  <= 1'b1;
      data_d1_r <= 1'b1;
      data_d2_r <= 1'b1;
    end else begin
      clk_d1_r  <= PS2_CLK;
      clk_d2_r  <= clk_d1_r;
      clk_d3_r  <= clk_d2_r;
      data_d1_r <= PS2_DATA;
      data_d2_r <= data_d1_r;
    end
  end

  // Down-counter in microseconds; a load wins over the ck1us decrement and
  // the count parks at zero, which is what "expired" means.
  always_ff @(posedge clk6x) begin
    if (reset) begin
      timer_r <= 16'd0;
    end else if (timer_load_s) begin
      timer_r <= timer_load_val_s;
    end else if (ck1us && !expired_s) begin
      timer_r <= timer_r - 16'd1;
    end else begin
      timer_r <= timer_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk6x) begin
    if (reset) begin
      state_r <= ST_WAIT_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic; a falling edge takes priority over a timeout.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nx_s = ST_INHIBIT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        if (expired_s) begin
          state_nx_s = ST_RTS;
        end else begin
          state_nx_s = ST_INHIBIT;
        end
      end
      ST_RTS: begin
        state_nx_s = ST_WF_FIRST;
      end
      ST_WF_FIRST: begin
        if (fall_s) begin
          state_nx_s = ST_BITS;
        end else if (expired_s) begin
          state_nx_s = ST_ERR;
        end else begin
          state_nx_s = ST_WF_FIRST;
        end
      end
      ST_BITS: begin
        if (fall_s) begin
          if (fall_n_s == 4'd11) begin
            if (data_d2_r) begin
              state_nx_s = ST_ERR;
            end else begin
              state_nx_s = ST_DONE_WAIT;
            end
          end else begin
            state_nx_s = ST_BITS;
          end
        end else if (expired_s) begin
          state_nx_s = ST_ERR;
        end else begin
          state_nx_s = ST_BITS;
        end
      end
      ST_ERR: begin
        state_nx_s = ST_WAIT_IDLE;
      end
      ST_DONE_WAIT: begin
        if (clk_d2_r && data_d2_r) begin
          state_nx_s = ST_WAIT_IDLE;
        end else begin
          state_nx_s = ST_DONE_WAIT;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_d3_r && clk_d2_r && data_d2_r && data_d1_r) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_nx_s = ST_WAIT_IDLE;
      end
    endcase
  end

  // FSM output logic: timer loads, DATA drive, bit count, error reason, pulses.
  always_comb begin
    timer_load_s     = 1'b0;
    timer_load_val_s = 16'd0;
    datadr0_nx_s     = datadr0_r;
    bitcnt_nx_s      = bitcnt_r;
    reason_nx_s      = reason_r;
    done_nx_s        = 1'b0;
    err_nx_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        datadr0_nx_s = 1'b0;
        bitcnt_nx_s  = 4'd0;
        reason_nx_s  = ERR_NONE;
        if (accept_s) begin
          timer_load_s     = 1'b1;
          timer_load_val_s = INHIBIT_LD;
        end else begin
          timer_load_s     = 1'b0;
        end
      end
      ST_INHIBIT: begin
        // Pull DATA low (start bit) once CLK has been held long enough.
        if (expired_s) begin
          datadr0_nx_s = 1'b1;
        end else begin
          datadr0_nx_s = 1'b0;
        end
      end
      ST_RTS: begin
        datadr0_nx_s     = 1'b1;
        bitcnt_nx_s      = 4'd0;
        timer_load_s     = 1'b1;
        timer_load_val_s = START_LD;
      end
      ST_WF_FIRST: begin
        if (fall_s) begin
          bitcnt_nx_s      = 4'd1;
          datadr0_nx_s     = drive_bit(4'd1, byte_r, parity_r);
          timer_load_s     = 1'b1;
          timer_load_val_s = PACKET_LD;
        end else if (expired_s) begin
          datadr0_nx_s = 1'b0;
          reason_nx_s  = ERR_NO_CLK;
        end else begin
          datadr0_nx_s = datadr0_r;
        end
      end
      ST_BITS: begin
        if (fall_s) begin
          bitcnt_nx_s  = fall_n_s;
          datadr0_nx_s = drive_bit(fall_n_s, byte_r, parity_r);
          if ((fall_n_s == 4'd11) && data_d2_r) begin
            reason_nx_s = ERR_NO_ACK;
          end else begin
            reason_nx_s = reason_r;
          end
        end else if (expired_s) begin
          datadr0_nx_s = 1'b0;
          reason_nx_s  = ERR_PKT_TO;
        end else begin
          datadr0_nx_s = datadr0_r;
        end
      end
      ST_ERR: begin
        datadr0_nx_s = 1'b0;
        err_nx_s     = 1'b1;
      end
      ST_DONE_WAIT: begin
        datadr0_nx_s = 1'b0;
        if (clk_d2_r && data_d2_r) begin
          done_nx_s = 1'b1;
        end else begin
          done_nx_s = 1'b0;
        end
      end
      ST_WAIT_IDLE: begin
        datadr0_nx_s = 1'b0;
      end
      default: begin
        datadr0_nx_s = 1'b0;
      end
    endcase
  end

  // Transfer datapath: latched byte, its parity, bit count and error reason.
  always_ff @(posedge clk6x) begin
    if (reset) begin
      byte_r   <= 8'd0;
      parity_r <= 1'b0;
      bitcnt_r <= 4'd0;
      reason_r <= ERR_NONE;
    end else begin
      if (accept_s) begin
        byte_r   <= code_tx_i;
        parity_r <= odd_parity(code_tx_i);
      end else begin
        byte_r   <= byte_r;
        parity_r <= parity_r;
      end
      bitcnt_r <= bitcnt_nx_s;
      reason_r <= reason_nx_s;
    end
  end

  // Output registers; CLK is only ever pulled low in INHIBIT and RTS.
  always_ff @(posedge clk6x) begin
    if (reset) begin
      clkdr0_r  <= 1'b0;
      datadr0_r <= 1'b0;
      ready_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      errcode_r <= ERR_NONE;
    end else begin
      clkdr0_r  <= (state_nx_s == ST_INHIBIT) || (state_nx_s == ST_RTS);
      datadr0_r <= datadr0_nx_s;
      ready_r   <= (state_nx_s == ST_IDLE);
      busy_r    <= (state_nx_s != ST_IDLE) && (state_nx_s != ST_WAIT_IDLE);
      done_r    <= done_nx_s;
      err_r     <= err_nx_s;
      if (err_nx_s) begin
        errcode_r <= reason_r;
      end else begin
        errcode_r <= errcode_r;
      end
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: directed + randomized bench for ps2_tx with an open-drain bus
// and a behavioural PS/2 device. Time base is scaled: 1 "us" = 4 clk6x.
module tb_ps2_tx;

  localparam int US_CYC   = 4;
  localparam int INH_US   = 120;
  localparam int START_US = 1500;
  localparam int PKT_US   = 2000;
  localparam int HALF     = 40 * US_CYC;   // device clock half-period (40 us)

  logic       clk6x;
  logic       reset;
  logic       ck1us;
  logic       ps2_clk_w;
  logic       ps2_data_w;
  logic       PS2_CLKDR0;
  logic       PS2_DATADR0;
  logic [7:0] code_tx_i;
  logic       code_tx_v_i;
  logic       code_tx_ready_o;
  logic       tx_busy_o;
  logic       tx_done_o;
  logic       tx_err_o;
  logic [1:0] tx_errcode_o;

  logic       dev_clk_lo;
  logic       dev_data_lo;

  int checks   = 0;
  int failures = 0;

  // Monitor state.
  int         cyc      = 0;
  int         done_cnt = 0;
  int         err_cnt  = 0;
  int         inh_cnt  = 0;
  int         err_cyc  = 0;
  logic [1:0] last_errcode = 2'b00;
  logic       clkdr_q  = 1'b0;

  // Device-side observations.
  logic       log_bits [1:11];
  int         inh_cycles;
  logic       data_at_rel;
  int         t_rel;
  int         t_fall1;

  // Open-drain wired-AND of host and device pull-downs.
  assign ps2_clk_w  = !(PS2_CLKDR0 || dev_clk_lo);
  assign ps2_data_w = !(PS2_DATADR0 || dev_data_lo);

  ps2_tx #(
    .INHIBIT_US        (INH_US),
    .START_TIMEOUT_US  (START_US),
    .PACKET_TIMEOUT_US (PKT_US)
  ) dut (
    .clk6x           (clk6x),
    .reset           (reset),
    .ck1us           (ck1us),
    .PS2_CLK         (ps2_clk_w),
    .PS2_DATA        (ps2_data_w),
    .PS2_CLKDR0      (PS2_CLKDR0),
    .PS2_DATADR0     (PS2_DATADR0),
    .code_tx_i       (code_tx_i),
    .code_tx_v_i     (code_tx_v_i),
    .code_tx_ready_o (code_tx_ready_o),
    .tx_busy_o       (tx_busy_o),
    .tx_done_o       (tx_done_o),
    .tx_err_o        (tx_err_o),
    .tx_errcode_o    (tx_errcode_o)
  );

  initial begin
    clk6x = 1'b0;
    forever #5 clk6x = ~clk6x;
  end

  // One-cycle microsecond strobe every US_CYC clocks.
  initial begin
    ck1us = 1'b0;
    forever begin
      repeat (US_CYC - 1) @(negedge clk6x);
      ck1us = 1'b1;
      @(negedge clk6x);
      ck1us = 1'b0;
    end
  end

  // Count pulses and inhibit starts, sampled on the falling edge.
  always @(negedge clk6x) begin
    cyc     <= cyc + 1;
    clkdr_q <= PS2_CLKDR0;
    if (tx_done_o) done_cnt <= done_cnt + 1;
    if (tx_err_o) begin
      err_cnt      <= err_cnt + 1;
      err_cyc      <= cyc;
      last_errcode <= tx_errcode_o;
    end
    if (PS2_CLKDR0 && !clkdr_q) inh_cnt <= inh_cnt + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Reference: what the device sees on DATA just before falling edge k
  // (1 = start, 2..9 = data LSB-first, 10 = odd parity, 11 = stop).
  function automatic logic model_sample(input logic [7:0] b, input int k);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    if (k == 1) return 1'b0;
    else if (k <= 9) return b[k-2];
    else if (k == 10) return (ones % 2 == 0);
    else return 1'b1;
  endfunction

  task automatic host_request(input logic [7:0] b);
    int guard;
    guard = 0;
    while (!code_tx_ready_o && guard < 2000) begin
      @(negedge clk6x);
      guard++;
    end
    check("ready_before_req", 32'(code_tx_ready_o), 32'd1);
    code_tx_i   = b;
    code_tx_v_i = 1'b1;
    @(negedge clk6x);
    code_tx_v_i = 1'b0;
    check("ready_drops", 32'(code_tx_ready_o), 32'd0);
    check("busy_rises", 32'(tx_busy_o), 32'd1);
  endtask

  // Behavioural device: observe inhibit/RTS, then issue n_clk clock pulses,
  // logging DATA before each fall; optionally ACK on the 11th clock.
  task automatic device_run(input int n_clk, input bit ack);
    int guard;
    guard = 0;
    while (ps2_clk_w && guard < 200) begin
      @(negedge clk6x);
      guard++;
    end
    check("inhibit_seen", 32'(ps2_clk_w), 32'd0);
    inh_cycles  = 0;
    data_at_rel = 1'b1;
    while (!ps2_clk_w && inh_cycles < (INH_US + 20) * US_CYC) begin
      data_at_rel = ps2_data_w;
      @(negedge clk6x);
      inh_cycles++;
    end
    t_rel = cyc;
    for (int k = 1; k <= 11; k++) log_bits[k] = 1'bx;
    repeat (10 * US_CYC) @(negedge clk6x);
    for (int k = 1; k <= n_clk; k++) begin
      log_bits[k] = ps2_data_w;
      dev_clk_lo  = 1'b1;
      if (k == 1) t_fall1 = cyc;
      if (k == 11 && ack) dev_data_lo = 1'b1;
      repeat (HALF) @(negedge clk6x);
      dev_clk_lo = 1'b0;
      repeat (HALF) @(negedge clk6x);
    end
    dev_data_lo = 1'b0;
  endtask

  task automatic frame_ok(input logic [7:0] b, input bit poke_busy);
    int          d0, e0, r0, guard;
    logic [10:0] exp_v, got_v;
    d0 = done_cnt; e0 = err_cnt; r0 = inh_cnt;
    host_request(b);
    if (poke_busy) begin
      // A request while not ready must be dropped, not queued.
      code_tx_i   = 8'h55;
      code_tx_v_i = 1'b1;
      @(negedge clk6x);
      code_tx_v_i = 1'b0;
    end
    device_run(11, 1'b1);
    guard = 0;
    while (!code_tx_ready_o && guard < 400) begin
      @(negedge clk6x);
      guard++;
    end
    check("ready_returns", 32'(code_tx_ready_o), 32'd1);
    for (int k = 1; k <= 11; k++) begin
      exp_v[k-1] = model_sample(b, k);
      got_v[k-1] = log_bits[k];
    end
    check($sformatf("frame_bits_%02h", b), 32'(got_v), 32'(exp_v));
    check($sformatf("parity_bit_%02h", b), 32'(log_bits[10]), 32'(model_sample(b, 10)));
    // The 1 us strobe grid and the sampling offset blur the bound by ~2 us.
    check_range("inhibit_len", inh_cycles, (INH_US - 2) * US_CYC, (INH_US + 2) * US_CYC);
    check("rts_data_low", 32'(data_at_rel), 32'd0);
    repeat (20) @(negedge clk6x);
    check("done_once", 32'(done_cnt - d0), 32'd1);
    check("no_err", 32'(err_cnt - e0), 32'd0);
    check("one_inhibit", 32'(inh_cnt - r0), 32'd1);
    check("lines_released", 32'({PS2_CLKDR0, PS2_DATADR0}), 32'd0);
    check("busy_clear", 32'(tx_busy_o), 32'd0);
  endtask

  task automatic wait_err(input int e0, input int limit);
    int guard;
    guard = 0;
    while (err_cnt == e0 && guard < limit) begin
      @(negedge clk6x);
      guard++;
    end
  endtask

  initial begin
    int          d0, e0;
    logic [7:0]  rb;

    reset       = 1'b1;
    code_tx_i   = 8'h00;
    code_tx_v_i = 1'b0;
    dev_clk_lo  = 1'b0;
    dev_data_lo = 1'b0;
    repeat (4) @(negedge clk6x);

    // Reset state.
    check("rst_clkdr0", 32'(PS2_CLKDR0), 32'd0);
    check("rst_datadr0", 32'(PS2_DATADR0), 32'd0);
    check("rst_ready", 32'(code_tx_ready_o), 32'd0);
    check("rst_busy", 32'(tx_busy_o), 32'd0);
    check("rst_pulses", 32'({tx_done_o, tx_err_o}), 32'd0);
    check("rst_errcode", 32'(tx_errcode_o), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk6x);
    check("ready_after_reset", 32'(code_tx_ready_o), 32'd1);

    // Directed frames, including a dropped request while busy.
    frame_ok(8'hED, 1'b1);
    frame_ok(8'h01, 1'b0);
    frame_ok(8'hFF, 1'b0);
    frame_ok(8'h00, 1'b0);

    // Random frames.
    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom_range(0, 255));
      frame_ok(rb, 1'b0);
    end

    // Device never clocks: no-clock error after START timeout.
    d0 = done_cnt; e0 = err_cnt;
    host_request(8'hF4);
    device_run(0, 1'b0);
    wait_err(e0, (START_US + 100) * US_CYC);
    check("noclk_err", 32'(err_cnt - e0), 32'd1);
    check("noclk_code", 32'(last_errcode), 32'd1);
    check_range("noclk_time", err_cyc - t_rel, (START_US - 1) * US_CYC, (START_US + 2) * US_CYC);
    check("noclk_lines", 32'({PS2_CLKDR0, PS2_DATADR0}), 32'd0);
    check("noclk_no_done", 32'(done_cnt - d0), 32'd0);

    // Device stops after 5 clocks: packet timeout.
    d0 = done_cnt; e0 = err_cnt;
    host_request(8'h5A);
    device_run(5, 1'b0);
    wait_err(e0, (PKT_US + 100) * US_CYC);
    check("pkt_err", 32'(err_cnt - e0), 32'd1);
    check("pkt_code", 32'(last_errcode), 32'd2);
    check_range("pkt_time", err_cyc - t_fall1, (PKT_US - 1) * US_CYC, (PKT_US + 2) * US_CYC);
    check("pkt_lines", 32'({PS2_CLKDR0, PS2_DATADR0}), 32'd0);
    check("pkt_no_done", 32'(done_cnt - d0), 32'd0);

    // Device leaves DATA high at the 11th clock: no-ACK error.
    d0 = done_cnt; e0 = err_cnt;
    host_request(8'h3C);
    device_run(11, 1'b0);
    wait_err(e0, 400);
    check("noack_err", 32'(err_cnt - e0), 32'd1);
    check("noack_code", 32'(last_errcode), 32'd3);
    check("noack_stop_bit", 32'(log_bits[11]), 32'd1);
    repeat (20) @(negedge clk6x);
    check("noack_no_done", 32'(done_cnt - d0), 32'd0);

    // Reset in the middle of the byte, then a clean 0xF4.
    d0 = done_cnt; e0 = err_cnt;
    host_request(8'hA5);
    device_run(4, 1'b0);
    check("mid_data_driven", 32'(PS2_DATADR0), 32'd1);
    reset = 1'b1;
    @(negedge clk6x);
    check("mid_rst_lines", 32'({PS2_CLKDR0, PS2_DATADR0}), 32'd0);
    check("mid_rst_busy", 32'(tx_busy_o), 32'd0);
    repeat (3) @(negedge clk6x);
    reset = 1'b0;
    repeat (20) @(negedge clk6x);
    check("mid_rst_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    frame_ok(8'hF4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
